// File: rtl/uart_cmd_parser_if.sv
// Register-write bus between the command parser and the VGA config register file.
// The master drives address, data and valid; the slave answers with ready.
interface uart_cmd_parser_if;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr_valid;
    logic        reg_wr_ready;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr_valid,
        input  reg_wr_ready
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr_valid,
        output reg_wr_ready
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns 5-byte packets {SYNC, ADDR, DATA_HI, DATA_LO, CHK}
// into a single 16-bit register write over a valid/ready handshake.
// Bad parity, bad checksum, inter-byte timeouts and frames arriving while a write
// is still pending are each counted in saturating error counters.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter bit          PARITY_ODD     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8:0]         frame,
    input  logic               frame_valid,
    uart_cmd_parser_if.master  wr,
    output logic               busy,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   parity_err_cnt,
    output logic [CNT_W-1:0]   chk_err_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StDhi,
        StDlo,
        StChk,
        StWrite
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      lo_q, lo_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] perr_cnt_q, perr_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic in_pkt;
    logic parity_ok;
    logic byte_ok;
    logic byte_bad;
    logic timeout;
    logic perr_evt;
    logic chk_evt;
    logic drop_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Decode the current frame and the inter-byte timeout condition.
    always_comb begin
        in_pkt    = (state_q == StAddr) || (state_q == StDhi) ||
                    (state_q == StDlo)  || (state_q == StChk);
        parity_ok = ((^frame) == PARITY_ODD);
        byte_ok   = frame_valid && parity_ok;
        byte_bad  = frame_valid && !parity_ok;
        // A frame arriving on the expiry cycle wins over the timeout.
        timeout   = in_pkt && !frame_valid && (tmo_q == TmoLast);
    end

    // Next-state, holding-register and error-event logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        perr_evt = 1'b0;
        chk_evt  = 1'b0;
        drop_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (byte_bad) begin
                    perr_evt = 1'b1;
                end else if (byte_ok && (frame[7:0] == SYNC_BYTE)) begin
                    state_d = StAddr;
                end
            end
            StAddr, StDhi, StDlo, StChk: begin
                if (byte_bad) begin
                    perr_evt = 1'b1;
                    state_d  = StIdle;
                end else if (timeout) begin
                    drop_evt = 1'b1;
                    state_d  = StIdle;
                end else if (byte_ok) begin
                    unique case (state_q)
                        StAddr: begin
                            addr_d  = frame[7:0];
                            state_d = StDhi;
                        end
                        StDhi: begin
                            hi_d    = frame[7:0];
                            state_d = StDlo;
                        end
                        StDlo: begin
                            lo_d    = frame[7:0];
                            state_d = StChk;
                        end
                        default: begin
                            if (frame[7:0] == (addr_q ^ hi_q ^ lo_q)) begin
                                state_d = StWrite;
                            end else begin
                                chk_evt = 1'b1;
                                state_d = StIdle;
                            end
                        end
                    endcase
                end
            end
            StWrite: begin
                // Overrun: the byte is lost but the pending write carries on.
                if (frame_valid) begin
                    drop_evt = 1'b1;
                end
                if (wr.reg_wr_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Timeout counter, error pulse and saturating counters.
    always_comb begin
        tmo_d      = (in_pkt && !frame_valid && !timeout) ? tmo_q + 1'b1 : '0;
        err_d      = perr_evt || chk_evt || drop_evt;
        perr_cnt_d = perr_evt ? sat_inc(perr_cnt_q) : perr_cnt_q;
        chk_cnt_d  = chk_evt  ? sat_inc(chk_cnt_q)  : chk_cnt_q;
        drop_cnt_d = drop_evt ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            perr_cnt_q <= '0;
            chk_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            perr_cnt_q <= perr_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        wr.reg_wr_valid = (state_q == StWrite);
        wr.reg_addr     = addr_q;
        wr.reg_wdata    = {hi_q, lo_q};
        busy            = (state_q != StIdle);
        err_pulse       = err_q;
        parity_err_cnt  = perr_cnt_q;
        chk_err_cnt     = chk_cnt_q;
        drop_cnt        = drop_cnt_q;
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed packet scenarios followed by randomized
// traffic, all checked every cycle against a packet-level reference model.
module tb_uart_cmd_parser;

    localparam int T    = 4096;
    localparam int CMAX = 255;

    logic       clk;
    logic       rst;
    logic [8:0] frame;
    logic       frame_valid;
    logic       busy;
    logic       err_pulse;
    logic [7:0] parity_err_cnt;
    logic [7:0] chk_err_cnt;
    logic [7:0] drop_cnt;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .PARITY_ODD     (1'b0),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .frame_valid    (frame_valid),
        .wr             (bus),
        .busy           (busy),
        .err_pulse      (err_pulse),
        .parity_err_cnt (parity_err_cnt),
        .chk_err_cnt    (chk_err_cnt),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes of the packet in progress, plus a pending write.
    logic [7:0]  m_pkt[$];
    bit          m_pend;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    int          m_last;
    int          cyc;
    int          m_perr, m_chk, m_drop;
    bit          m_err;
    int          m_writes;
    int          obs_writes;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    function automatic logic [8:0] mk(input logic [7:0] b, input bit bad);
        logic p;
        p = (^b) ^ bad;
        return {p, b};
    endfunction

    task automatic model_reset();
        m_pkt.delete();
        m_pend     = 0;
        m_addr     = '0;
        m_data     = '0;
        m_perr     = 0;
        m_chk      = 0;
        m_drop     = 0;
        m_err      = 0;
        m_writes   = 0;
        obs_writes = 0;
        m_last     = cyc;
    endtask

    task automatic model_step(input bit fv, input logic [8:0] fr, input bit rdy);
        bit good;
        logic [7:0] cs;
        cyc++;
        m_err = 0;
        good  = ((^fr) == 1'b0);
        if (m_pend) begin
            if (fv) begin
                m_drop = sat(m_drop);
                m_err  = 1;
            end
            if (rdy) begin
                m_pend = 0;
                m_writes++;
            end
        end else if (m_pkt.size() == 0) begin
            if (fv) begin
                if (!good) begin
                    m_perr = sat(m_perr);
                    m_err  = 1;
                end else if (fr[7:0] == 8'hA5) begin
                    m_pkt.push_back(fr[7:0]);
                    m_last = cyc;
                end
            end
        end else begin
            if (fv) begin
                if (!good) begin
                    m_perr = sat(m_perr);
                    m_err  = 1;
                    m_pkt.delete();
                end else begin
                    m_last = cyc;
                    if (m_pkt.size() < 4) begin
                        m_pkt.push_back(fr[7:0]);
                    end else begin
                        cs = m_pkt[1] ^ m_pkt[2] ^ m_pkt[3];
                        if (fr[7:0] == cs) begin
                            m_pend = 1;
                            m_addr = m_pkt[1];
                            m_data = {m_pkt[2], m_pkt[3]};
                        end else begin
                            m_chk = sat(m_chk);
                            m_err = 1;
                        end
                        m_pkt.delete();
                    end
                end
            end else if (cyc - m_last == T) begin
                m_drop = sat(m_drop);
                m_err  = 1;
                m_pkt.delete();
            end
        end
    endtask

    task automatic compare_all();
        check_val("valid", bus.reg_wr_valid, m_pend);
        if (m_pend) begin
            check_val("addr", bus.reg_addr, m_addr);
            check_val("wdata", bus.reg_wdata, m_data);
        end
        check_val("busy", busy, (m_pkt.size() != 0) || m_pend);
        check_val("err_pulse", err_pulse, m_err);
        check_val("parity_err_cnt", parity_err_cnt, m_perr);
        check_val("chk_err_cnt", chk_err_cnt, m_chk);
        check_val("drop_cnt", drop_cnt, m_drop);
    endtask

    // One clock: apply inputs, step the model at the edge, check 1 ns later.
    task automatic cycle(input bit fv, input logic [8:0] fr, input bit rdy);
        frame_valid      = fv;
        frame            = fr;
        bus.reg_wr_ready = rdy;
        if (bus.reg_wr_valid && rdy) obs_writes++;
        @(posedge clk);
        model_step(fv, fr, rdy);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input bit bad, input bit rdy);
        cycle(1'b1, mk(b, bad), rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, rdy);
    endtask

    task automatic idle_rand(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, ($urandom % 3) != 0);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, input bit rdy);
        send(8'hA5, 1'b0, rdy);
        send(a, 1'b0, rdy);
        send(h, 1'b0, rdy);
        send(l, 1'b0, rdy);
        send(c, 1'b0, rdy);
    endtask

    // Asynchronous reset pulse, asserted mid-cycle.
    task automatic reset_pulse();
        frame_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_val("rst_addr", bus.reg_addr, 8'h00);
        check_val("rst_wdata", bus.reg_wdata, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] pk[5];
        rst              = 1'b0;
        frame            = '0;
        frame_valid      = 1'b0;
        bus.reg_wr_ready = 1'b0;
        cyc              = 0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        check_val("rst_addr", bus.reg_addr, 8'h00);
        check_val("rst_wdata", bus.reg_wdata, 16'h0000);
        rst = 1'b1;

        // 1: good packet, write visible the cycle after the CHK byte
        send_pkt(8'h10, 8'h12, 8'h34, 8'h36, 1'b1);
        check_val("t1_valid", bus.reg_wr_valid, 1'b1);
        check_val("t1_addr", bus.reg_addr, 8'h10);
        check_val("t1_wdata", bus.reg_wdata, 16'h1234);
        idle(2, 1'b1);
        check_val("t1_writes", obs_writes, 1);

        // 2: bad checksum
        reset_pulse();
        send_pkt(8'h10, 8'h12, 8'h34, 8'h00, 1'b1);
        check_val("t2_err", err_pulse, 1'b1);
        check_val("t2_chk", chk_err_cnt, 8'd1);
        idle(1, 1'b1);
        check_val("t2_err_gone", err_pulse, 1'b0);
        check_val("t2_busy", busy, 1'b0);
        idle(2, 1'b1);
        check_val("t2_writes", obs_writes, 0);

        // 3: DATA_HI with flipped parity, then a good packet
        reset_pulse();
        send(8'hA5, 1'b0, 1'b1);
        send(8'h10, 1'b0, 1'b1);
        send(8'h12, 1'b1, 1'b1);
        check_val("t3_perr", parity_err_cnt, 8'd1);
        idle(3, 1'b1);
        send_pkt(8'h20, 8'hBE, 8'hEF, 8'h20 ^ 8'hBE ^ 8'hEF, 1'b1);
        idle(2, 1'b1);
        check_val("t3_writes", obs_writes, 1);

        // 4: backpressure with one overrun frame
        reset_pulse();
        send_pkt(8'h10, 8'h12, 8'h34, 8'h36, 1'b0);
        idle(5, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        idle(14, 1'b0);
        check_val("t4_valid", bus.reg_wr_valid, 1'b1);
        check_val("t4_wdata", bus.reg_wdata, 16'h1234);
        check_val("t4_drop", drop_cnt, 8'd1);
        cycle(1'b0, 9'h000, 1'b1);
        idle(2, 1'b0);
        check_val("t4_writes", obs_writes, 1);

        // 5: timeout after A5,10, then junk in IDLE
        reset_pulse();
        send(8'hA5, 1'b0, 1'b1);
        send(8'h10, 1'b0, 1'b1);
        idle(T - 10, 1'b1);
        check_val("t5_busy_before", busy, 1'b1);
        idle(15, 1'b1);
        check_val("t5_drop", drop_cnt, 8'd1);
        check_val("t5_busy", busy, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        idle(1, 1'b1);
        check_val("t5_perr", parity_err_cnt, 8'd0);
        check_val("t5_drop_after", drop_cnt, 8'd1);

        // 6: reset between DHI and DLO, resend, then saturate parity errors
        reset_pulse();
        send(8'hA5, 1'b0, 1'b1);
        send(8'h10, 1'b0, 1'b1);
        send(8'h12, 1'b0, 1'b1);
        reset_pulse();
        check_val("t6_busy", busy, 1'b0);
        send_pkt(8'h10, 8'h12, 8'h34, 8'h36, 1'b1);
        idle(2, 1'b1);
        check_val("t6_writes", obs_writes, 1);
        check_val("t6_drop", drop_cnt, 8'd0);
        for (int i = 0; i < 300; i++) send(8'h3C, 1'b1, 1'b1);
        idle(1, 1'b1);
        check_val("t6_perr_sat", parity_err_cnt, 8'd255);

        // Randomized traffic
        reset_pulse();
        for (int p = 0; p < 60; p++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                send(8'($urandom), ($urandom % 4) == 0, ($urandom % 3) != 0);
                idle_rand($urandom_range(0, 2));
            end
            pk[0] = 8'hA5;
            pk[1] = 8'($urandom);
            pk[2] = 8'($urandom);
            pk[3] = 8'($urandom);
            pk[4] = pk[1] ^ pk[2] ^ pk[3];
            if (($urandom % 7) == 0) pk[4] = pk[4] ^ 8'h01;
            for (int k = 0; k < 5; k++) begin
                send(pk[k], ($urandom % 20) == 0, ($urandom % 3) != 0);
                if ((p == 20 || p == 40) && k == 1) begin
                    idle_rand(T + 2);
                    break;
                end
                idle_rand($urandom_range(0, 4));
            end
        end
        idle(4, 1'b1);
        check_val("rand_writes", obs_writes, m_writes);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
